sprite_compositor: RTL and testbench

//  N-channel sprite compositor and collision detector for the 640x480 video pipeline.
//  - Sits between the per-sprite pixel generators and the color mapper.
//  - Priority-muxes N sprite pixels over a background colour code.
//  - Accumulates a pairwise collision matrix, a hit-pixel count and the first-hit

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/collision_accumulator.sv | 95 +++++++++
 rtl/sprite_compositor.sv | 142 ++++++++++++++
 tb/tb_sprite_compositor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite-pipeline types and helpers: pair numbering for the collision matrix, colour type, defaults.
// Pure declarations, no latency and no flow control.
package sprite_pkg;

  localparam int          COLR_BITS_DEF    = 12;
  localparam int          SCREEN_CORDW_DEF = 16;
  localparam int unsigned BG_COLR_DEF      = 15;

  typedef logic [COLR_BITS_DEF-1:0] colr_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACCUM      = 1'b1
  } comp_state_t;

  function automatic int n_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Column-major triangle numbering for i < j, so the index does not depend on the sprite count.
  function automatic int pair_idx(input int i, input int j);
    return j * (j - 1) / 2 + i;
  endfunction

endpackage

// File: rtl/collision_accumulator.sv
// Per-frame collision accumulation (pair OR matrix, saturating hit counter, first-hit capture) and publish registers.
// Results land one cycle after the publish strobe; no backpressure, consumer must sample on frame_done.
module collision_accumulator
  import sprite_pkg::*;
#(
  parameter int N_PAIRS      = 6,
  parameter int SCREEN_CORDW = SCREEN_CORDW_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic [N_PAIRS-1:0]      pair_hit,
  input  logic                    acc_start,
  input  logic                    acc_run,
  input  logic                    publish,
  input  logic                    clear_sticky,
  input  logic [SCREEN_CORDW-1:0] screen_x,
  input  logic [SCREEN_CORDW-1:0] screen_y,
  output logic [N_PAIRS-1:0]      collision_pairs,
  output logic [N_PAIRS-1:0]      collision_sticky,
  output logic [CNT_W-1:0]        hit_count,
  output logic [SCREEN_CORDW-1:0] hit_x,
  output logic [SCREEN_CORDW-1:0] hit_y,
  output logic                    hit_valid,
  output logic                    frame_done
);

  logic [N_PAIRS-1:0]      acc_pairs;
  logic [CNT_W-1:0]        acc_cnt;
  logic [SCREEN_CORDW-1:0] acc_x;
  logic [SCREEN_CORDW-1:0] acc_y;
  logic                    acc_hv;
  logic                    any_hit;

  assign any_hit = |pair_hit;

  // A frame strobe restarts accumulation seeded with that cycle's own hit.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      acc_pairs <= '0;
      acc_cnt   <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      acc_hv    <= 1'b0;
    end else if (acc_start) begin
      acc_pairs <= pair_hit;
      acc_cnt   <= CNT_W'(any_hit);
      acc_hv    <= any_hit;
      acc_x     <= any_hit ? screen_x : '0;
      acc_y     <= any_hit ? screen_y : '0;
    end else if (acc_run && any_hit) begin
      acc_pairs <= acc_pairs | pair_hit;
      if (acc_cnt != {CNT_W{1'b1}}) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (!acc_hv) begin
        acc_hv <= 1'b1;
        acc_x  <= screen_x;
        acc_y  <= screen_y;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      collision_pairs <= '0;
      hit_count       <= '0;
      hit_x           <= '0;
      hit_y           <= '0;
      hit_valid       <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        collision_pairs <= acc_pairs;
        hit_count       <= acc_cnt;
        hit_x           <= acc_x;
        hit_y           <= acc_y;
        hit_valid       <= acc_hv;
      end
    end
  end

  // A clear coinciding with a publish keeps only the freshly published pairs.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      collision_sticky <= '0;
    end else if (publish) begin
      collision_sticky <= clear_sticky ? acc_pairs : (collision_sticky | acc_pairs);
    end else if (clear_sticky) begin
      collision_sticky <= '0;
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Priority-muxes N sprite pixels over background (1-cycle registered) and publishes per-frame collision results.
// Always accepts a pixel per clock; no backpressure.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          N_SPRITES    = 4,
  parameter int          COLR_BITS    = COLR_BITS_DEF,
  parameter int          SCREEN_CORDW = SCREEN_CORDW_DEF,
  parameter int unsigned BG_COLR      = BG_COLR_DEF,
  parameter int          CNT_W        = 16
) (
  input  logic                               clk_pix,
  input  logic                               rst_n,
  input  logic                               frame,
  input  logic                               de,
  input  logic [SCREEN_CORDW-1:0]            screen_x,
  input  logic [SCREEN_CORDW-1:0]            screen_y,
  input  logic [N_SPRITES-1:0]               spr_drawing,
  input  logic [N_SPRITES*COLR_BITS-1:0]     spr_pixel,
  input  logic [N_SPRITES-1:0]               collide_mask,
  input  logic                               clear_sticky,
  output logic [COLR_BITS-1:0]               pix_out,
  output logic [$clog2(N_SPRITES+1)-1:0]     pix_id,
  output logic [n_pairs(N_SPRITES)-1:0]      collision_pairs,
  output logic [n_pairs(N_SPRITES)-1:0]      collision_sticky,
  output logic                               collision_any,
  output logic [CNT_W-1:0]                   hit_count,
  output logic [SCREEN_CORDW-1:0]            hit_x,
  output logic [SCREEN_CORDW-1:0]            hit_y,
  output logic                               hit_valid,
  output logic                               frame_done
);

  localparam int N_PAIRS = n_pairs(N_SPRITES);
  localparam int ID_W    = $clog2(N_SPRITES + 1);

  logic [1:0]           rst_sync;
  logic                 rst_i;
  comp_state_t          state;
  comp_state_t          state_nxt;
  logic                 acc_start;
  logic                 acc_run;
  logic                 publish;
  logic [COLR_BITS-1:0] win_pix;
  logic [ID_W-1:0]      win_id;
  logic [N_PAIRS-1:0]   pair_hit;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_i = rst_sync[1];

  always_comb begin
    win_pix = COLR_BITS'(BG_COLR);
    win_id  = ID_W'(N_SPRITES);
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (spr_drawing[i]) begin
        win_pix = spr_pixel[i*COLR_BITS +: COLR_BITS];
        win_id  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_i) begin
    if (!rst_i) begin
      pix_out <= COLR_BITS'(BG_COLR);
      pix_id  <= ID_W'(N_SPRITES);
    end else begin
      pix_out <= win_pix;
      pix_id  <= win_id;
    end
  end

  always_comb begin
    pair_hit = '0;
    for (int j = 1; j < N_SPRITES; j++) begin
      for (int i = 0; i < j; i++) begin
        pair_hit[pair_idx(i, j)] = de & spr_drawing[i] & spr_drawing[j]
                                 & collide_mask[i] & collide_mask[j];
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_i) begin
    if (!rst_i) begin
      state <= WAIT_FRAME;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FRAME: if (frame) state_nxt = ACCUM;
      ACCUM:      state_nxt = ACCUM;
      default:    state_nxt = WAIT_FRAME;
    endcase
  end

  // The partial frame seen after reset is never published, only restarted.
  always_comb begin
    acc_start = frame;
    acc_run   = 1'b0;
    publish   = 1'b0;
    if (state == ACCUM) begin
      acc_run = 1'b1;
      publish = frame;
    end
  end

  collision_accumulator #(
    .N_PAIRS      (N_PAIRS),
    .SCREEN_CORDW (SCREEN_CORDW),
    .CNT_W        (CNT_W)
  ) u_acc (
    .clk_pix          (clk_pix),
    .rst_n            (rst_i),
    .pair_hit         (pair_hit),
    .acc_start        (acc_start),
    .acc_run          (acc_run),
    .publish          (publish),
    .clear_sticky     (clear_sticky),
    .screen_x         (screen_x),
    .screen_y         (screen_y),
    .collision_pairs  (collision_pairs),
    .collision_sticky (collision_sticky),
    .hit_count        (hit_count),
    .hit_x            (hit_x),
    .hit_y            (hit_y),
    .hit_valid        (hit_valid),
    .frame_done       (frame_done)
  );

  assign collision_any = |collision_pairs;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized and directed bench for sprite_compositor against a frame-level behavioural model.
module tb_sprite_compositor;

  localparam int N   = 4;
  localparam int CB  = 12;
  localparam int CW  = 16;
  localparam int CNT = 4;
  localparam int NP  = 6;
  localparam int BG  = 15;
  localparam int SAT = 15;

  logic          clk_pix = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame = 1'b0;
  logic          de = 1'b0;
  logic [CW-1:0] screen_x = '0;
  logic [CW-1:0] screen_y = '0;
  logic [N-1:0]  spr_drawing = '0;
  logic [N*CB-1:0] spr_pixel = '0;
  logic [N-1:0]  collide_mask = '0;
  logic          clear_sticky = 1'b0;

  logic [CB-1:0]  pix_out;
  logic [2:0]     pix_id;
  logic [NP-1:0]  collision_pairs;
  logic [NP-1:0]  collision_sticky;
  logic           collision_any;
  logic [CNT-1:0] hit_count;
  logic [CW-1:0]  hit_x;
  logic [CW-1:0]  hit_y;
  logic           hit_valid;
  logic           frame_done;

  sprite_compositor #(
    .N_SPRITES(N), .COLR_BITS(CB), .SCREEN_CORDW(CW), .BG_COLR(BG), .CNT_W(CNT)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .de(de),
    .screen_x(screen_x), .screen_y(screen_y), .spr_drawing(spr_drawing),
    .spr_pixel(spr_pixel), .collide_mask(collide_mask), .clear_sticky(clear_sticky),
    .pix_out(pix_out), .pix_id(pix_id), .collision_pairs(collision_pairs),
    .collision_sticky(collision_sticky), .collision_any(collision_any),
    .hit_count(hit_count), .hit_x(hit_x), .hit_y(hit_y), .hit_valid(hit_valid),
    .frame_done(frame_done)
  );

  always #20 clk_pix = ~clk_pix;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_pix, m_id, rst_hold;
  bit            running, m_done;
  bit [NP-1:0]   acc_p, pub_p, m_sticky;
  int            acc_c, pub_c;
  bit            acc_v, pub_v;
  logic [CW-1:0] acc_x, acc_y, pub_x, pub_y;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Triangle enumeration: pairs listed by higher sprite j, then lower sprite i.
  function automatic int pidx(input int a, input int b);
    int k = 0;
    int r = -1;
    for (int j = 1; j < N; j++)
      for (int i = 0; i < j; i++) begin
        if (i == a && j == b) r = k;
        k++;
      end
    return r;
  endfunction

  task automatic model_reset();
    m_pix = BG; m_id = N; rst_hold = 2;
    running = 0; m_done = 0;
    acc_p = '0; pub_p = '0; m_sticky = '0;
    acc_c = 0; pub_c = 0; acc_v = 0; pub_v = 0;
    acc_x = '0; acc_y = '0; pub_x = '0; pub_y = '0;
  endtask

  task automatic model_step();
    bit [NP-1:0] hv;
    bit          found;
    if (!rst_n) begin
      model_reset();
    end else if (rst_hold > 0) begin
      rst_hold--;
    end else begin
      found = 0;
      m_pix = BG; m_id = N;
      for (int i = 0; i < N; i++)
        if (!found && spr_drawing[i]) begin
          found = 1; m_pix = int'(spr_pixel[i*CB +: CB]); m_id = i;
        end
      hv = '0;
      for (int a = 0; a < N; a++)
        for (int b = a + 1; b < N; b++)
          if (de && spr_drawing[a] && spr_drawing[b] && collide_mask[a] && collide_mask[b])
            hv[pidx(a, b)] = 1'b1;
      m_done = 0;
      if (frame) begin
        if (running) begin
          pub_p = acc_p; pub_c = acc_c; pub_v = acc_v; pub_x = acc_x; pub_y = acc_y;
          m_done = 1;
          m_sticky = clear_sticky ? acc_p : (m_sticky | acc_p);
        end else if (clear_sticky) begin
          m_sticky = '0;
        end
        running = 1; acc_p = '0; acc_c = 0; acc_v = 0;
      end else if (clear_sticky) begin
        m_sticky = '0;
      end
      if (running && hv != '0) begin
        acc_p |= hv;
        if (acc_c < SAT) acc_c++;
        if (!acc_v) begin
          acc_v = 1; acc_x = screen_x; acc_y = screen_y;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("pix_out", 64'(pix_out), 64'(m_pix));
    check("pix_id", 64'(pix_id), 64'(m_id));
    check("frame_done", 64'(frame_done), 64'(m_done));
    check("pairs", 64'(collision_pairs), 64'(pub_p));
    check("sticky", 64'(collision_sticky), 64'(m_sticky));
    check("any", 64'(collision_any), 64'(pub_p != '0));
    check("hit_count", 64'(hit_count), 64'(pub_c));
    check("hit_valid", 64'(hit_valid), 64'(pub_v));
    if (pub_v) begin
      check("hit_x", 64'(hit_x), 64'(pub_x));
      check("hit_y", 64'(hit_y), 64'(pub_y));
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic rand_pixels();
    for (int i = 0; i < N; i++) spr_pixel[i*CB +: CB] = CB'($urandom);
  endtask

  task automatic idle(input int n);
    de = 0; spr_drawing = '0; frame = 0; clear_sticky = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_frame(input bit clr);
    de = 0; spr_drawing = '0; frame = 1; clear_sticky = clr;
    tick();
    frame = 0; clear_sticky = 0;
  endtask

  // Sprite 1 covers x 99..102, y 200..201; sprite 3 covers x 100..104, y 200..202.
  task automatic picture(input logic [N-1:0] mask);
    collide_mask = mask;
    for (int y = 199; y <= 202; y++)
      for (int x = 98; x <= 105; x++) begin
        de = 1; screen_x = CW'(x); screen_y = CW'(y);
        rand_pixels();
        spr_drawing = '0;
        spr_drawing[1] = (x >= 99 && x <= 102 && y >= 200 && y <= 201);
        spr_drawing[3] = (x >= 100 && x <= 104 && y >= 200 && y <= 202);
        tick();
      end
    idle(2);
  endtask

  task automatic pair_run(input int a, input int b, input int n);
    collide_mask = '1;
    for (int k = 0; k < n; k++) begin
      de = 1; screen_x = CW'(10 + k); screen_y = CW'(50);
      spr_drawing = '0; spr_drawing[a] = 1; spr_drawing[b] = 1;
      rand_pixels();
      tick();
    end
    idle(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    idle(3);
    check("rst pix_out", 64'(pix_out), 64'(BG));
    check("rst pix_id", 64'(pix_id), 64'(N));
    check("rst hit_x", 64'(hit_x), 64'd0);
    check("rst hit_y", 64'(hit_y), 64'd0);
    rst_n = 1;
    idle(4);

    // Compositing priority and background
    spr_drawing = 4'b0101;
    spr_pixel = '0; spr_pixel[0 +: CB] = 12'd5; spr_pixel[2*CB +: CB] = 12'd9;
    tick();
    check("prio pix_out", 64'(pix_out), 64'd5);
    check("prio pix_id", 64'(pix_id), 64'd0);
    spr_drawing = '0;
    tick();
    check("bg pix_out", 64'(pix_out), 64'd15);
    check("bg pix_id", 64'(pix_id), 64'd4);

    // First frame after reset is never published
    pulse_frame(0);
    check("first frame no done", 64'(frame_done), 64'd0);
    picture(4'hF);
    pulse_frame(0);
    check("ovl done", 64'(frame_done), 64'd1);
    check("ovl pairs", 64'(collision_pairs), 64'h10);
    check("ovl count", 64'(hit_count), 64'd6);
    check("ovl hit_x", 64'(hit_x), 64'd100);
    check("ovl hit_y", 64'(hit_y), 64'd200);
    check("ovl valid", 64'(hit_valid), 64'd1);
    tick();
    check("done is pulse", 64'(frame_done), 64'd0);

    // Masked-out sprite 3: no collision, compositing unchanged
    collide_mask = 4'b0111;
    de = 1; spr_drawing = 4'b1010; rand_pixels();
    tick();
    check("masked comp id", 64'(pix_id), 64'd1);
    picture(4'b0111);
    pulse_frame(0);
    check("masked pairs", 64'(collision_pairs), 64'd0);
    check("masked count", 64'(hit_count), 64'd0);
    check("masked valid", 64'(hit_valid), 64'd0);
    check("masked sticky", 64'(collision_sticky), 64'h10);

    // Sticky across frames k, k+1, then clear
    picture(4'hF);
    pulse_frame(0);
    check("k pairs", 64'(collision_pairs), 64'h10);
    check("k sticky", 64'(collision_sticky), 64'h10);
    idle(10);
    pulse_frame(0);
    check("k1 pairs", 64'(collision_pairs), 64'd0);
    check("k1 sticky", 64'(collision_sticky), 64'h10);
    clear_sticky = 1;
    tick();
    clear_sticky = 0;
    check("k2 sticky", 64'(collision_sticky), 64'd0);

    // Saturation and clear coincident with publish
    pair_run(2, 3, 5);
    pulse_frame(0);
    check("p23 sticky", 64'(collision_sticky), 64'h20);
    pair_run(0, 1, 40);
    pulse_frame(1);
    check("sat count", 64'(hit_count), 64'd15);
    check("sat pairs", 64'(collision_pairs), 64'h01);
    check("clr+pub sticky", 64'(collision_sticky), 64'h01);

    // Randomized frames, including hits on the frame cycle and stray clears
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(20, 120);
      for (int k = 0; k < len; k++) begin
        de = ($urandom_range(0, 3) != 0);
        screen_x = CW'($urandom_range(0, 639));
        screen_y = CW'($urandom_range(0, 479));
        spr_drawing = N'($urandom);
        collide_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
        clear_sticky = ($urandom_range(0, 31) == 0);
        frame = (k == len - 1);
        rand_pixels();
        tick();
      end
      frame = 0; clear_sticky = 0;
    end
    idle(3);

    // Asynchronous reset in the middle of an overlapping frame
    collide_mask = '1;
    for (int k = 0; k < 5; k++) begin
      de = 1; screen_x = CW'(k); screen_y = CW'(7); spr_drawing = 4'b0011; rand_pixels();
      tick();
    end
    #5 rst_n = 0;
    #1;
    model_reset();
    compare_all();
    check("midrst pix_id", 64'(pix_id), 64'd4);
    check("midrst count", 64'(hit_count), 64'd0);
    tick();
    idle(2);
    rst_n = 1;
    idle(4);
    pulse_frame(0);
    check("postrst no done", 64'(frame_done), 64'd0);
    check("postrst pairs", 64'(collision_pairs), 64'd0);
    picture(4'hF);
    pulse_frame(0);
    check("postrst done", 64'(frame_done), 64'd1);
    check("postrst pairs2", 64'(collision_pairs), 64'h10);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
